// File: rtl/led_matrix_scan_ctrl_if.sv
// ============================================================================
// led_matrix_scan_ctrl_if : frame-store read port, buffer-swap handshake and
//                           74HC595 chain pins of the LED matrix scanner.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface led_matrix_scan_ctrl_if #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int DEPTH = 2
);
    localparam int AW = $clog2(ROWS) + 1;

    logic                    enable;
    logic                    pix_rd;
    logic [AW-1:0]           pix_addr;
    logic [COLS*DEPTH-1:0]   pix_data;
    logic                    swap_req;
    logic                    swap_ack;
    logic                    disp_buf;
    logic                    sclk;
    logic                    serial_data;
    logic                    rclk;
    logic                    clear;
    logic                    frame_done;

    modport master (
        input  enable, pix_data, swap_req,
        output pix_rd, pix_addr, swap_ack, disp_buf, sclk, serial_data, rclk, clear, frame_done
    );

    modport slave (
        output enable, pix_data, swap_req,
        input  pix_rd, pix_addr, swap_ack, disp_buf, sclk, serial_data, rclk, clear, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/led_matrix_scan_ctrl.sv
// ============================================================================
// led_matrix_scan_ctrl : row-scan sequencer with bit-plane PWM for a 16x16
//                        LED matrix behind a 32-bit 74HC595 chain.
// Revision: 1.0
// ============================================================================
`default_nettype none

module led_matrix_scan_ctrl #(
    parameter int ROWS    = 16,
    parameter int COLS    = 16,
    parameter int DEPTH   = 2,
    parameter int CLK_DIV = 100
) (
    input  logic                   clk,
    input  logic                   rst,
    led_matrix_scan_ctrl_if.master bus
);
    localparam int PLANES = (1 << DEPTH) - 1;
    localparam int NBITS  = COLS + ROWS;
    localparam int RW     = $clog2(ROWS);
    localparam int BW     = $clog2(NBITS);
    localparam int DW     = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SHIFT = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t                 state_q;
    logic [DW-1:0]          div_q;
    logic                   fetch_ph_q;
    logic                   half_q;
    logic [BW-1:0]          bit_q;
    logic [RW-1:0]          row_q;
    logic [DEPTH-1:0]       plane_q;
    logic [COLS*DEPTH-1:0]  pix_q;

    logic                   pix_rd_q;
    logic [RW:0]            pix_addr_q;
    logic                   swap_ack_q;
    logic                   disp_q;
    logic                   sclk_q;
    logic                   sdata_q;
    logic                   rclk_q;
    logic                   clear_q;
    logic                   frame_done_q;

    logic                   tick;
    logic                   last_row;
    logic                   last_plane;
    logic                   frame_end;
    logic [RW-1:0]          row_d;
    logic [DEPTH-1:0]       plane_d;
    logic                   disp_d;
    logic [NBITS-1:0]       line_bits;

    assign tick       = (div_q == DW'(CLK_DIV - 1));
    assign last_row   = (row_q == RW'(ROWS - 1));
    assign last_plane = (plane_q == DEPTH'(PLANES - 1));
    assign frame_end  = last_row & last_plane;
    assign row_d      = last_row ? '0 : row_q + 1'b1;
    assign plane_d    = last_row ? (last_plane ? '0 : plane_q + 1'b1) : plane_q;
    assign disp_d     = disp_q ^ (frame_end & bus.swap_req);

    // Shift order: anodes first, highest column first, then cathodes row 0 upward.
    for (genvar c = 0; c < COLS; c++) begin : g_anode
        assign line_bits[c] = (pix_q[(COLS-1-c)*DEPTH +: DEPTH] > plane_q);
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_cathode
        assign line_bits[COLS+r] = (row_q != RW'(r));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            fetch_ph_q   <= 1'b0;
            half_q       <= 1'b0;
            bit_q        <= '0;
            row_q        <= '0;
            plane_q      <= '0;
            pix_q        <= '0;
            pix_rd_q     <= 1'b0;
            pix_addr_q   <= '0;
            swap_ack_q   <= 1'b0;
            disp_q       <= 1'b0;
            sclk_q       <= 1'b0;
            sdata_q      <= 1'b0;
            rclk_q       <= 1'b0;
            clear_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            clear_q      <= 1'b1;
            pix_rd_q     <= 1'b0;
            swap_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    sclk_q  <= 1'b0;
                    rclk_q  <= 1'b0;
                    sdata_q <= 1'b0;
                    div_q   <= '0;
                    if (bus.enable) begin
                        state_q    <= S_FETCH;
                        fetch_ph_q <= 1'b0;
                        pix_rd_q   <= 1'b1;
                        pix_addr_q <= {disp_q, row_q};
                    end
                end
                S_FETCH: begin
                    div_q <= '0;
                    if (!fetch_ph_q) begin
                        fetch_ph_q <= 1'b1;
                    end else begin
                        pix_q   <= bus.pix_data;
                        bit_q   <= '0;
                        half_q  <= 1'b0;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    div_q <= tick ? '0 : div_q + 1'b1;
                    if (tick) begin
                        if (!half_q) begin
                            sdata_q <= line_bits[bit_q];
                            sclk_q  <= 1'b0;
                            half_q  <= 1'b1;
                        end else begin
                            sclk_q <= 1'b1;
                            half_q <= 1'b0;
                            if (bit_q == BW'(NBITS - 1)) begin
                                state_q <= S_LATCH;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end
                    end
                end
                S_LATCH: begin
                    div_q <= tick ? '0 : div_q + 1'b1;
                    if (tick) begin
                        if (!half_q) begin
                            rclk_q <= 1'b1;
                            sclk_q <= 1'b0;
                            half_q <= 1'b1;
                        end else begin
                            rclk_q  <= 1'b0;
                            half_q  <= 1'b0;
                            row_q   <= row_d;
                            plane_q <= plane_d;
                            disp_q  <= disp_d;
                            // swap_req is only honoured at the frame boundary
                            if (frame_end) begin
                                frame_done_q <= 1'b1;
                                swap_ack_q   <= bus.swap_req;
                            end
                            if (bus.enable) begin
                                state_q    <= S_FETCH;
                                fetch_ph_q <= 1'b0;
                                pix_rd_q   <= 1'b1;
                                pix_addr_q <= {disp_d, row_d};
                            end else begin
                                state_q <= S_IDLE;
                                sdata_q <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.pix_rd      = pix_rd_q;
    assign bus.pix_addr    = pix_addr_q;
    assign bus.swap_ack    = swap_ack_q;
    assign bus.disp_buf    = disp_q;
    assign bus.sclk        = sclk_q;
    assign bus.serial_data = sdata_q;
    assign bus.rclk        = rclk_q;
    assign bus.clear       = clear_q;
    assign bus.frame_done  = frame_done_q;

endmodule

`default_nettype wire
